// File: rtl/cmp_pkg.sv
// Shared types and constants for the CMP run controller/monitor.
package cmp_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_DUMP  = 3'd2,
    ST_DONE  = 3'd3,
    ST_TOUT  = 3'd4
  } cmp_state_e;

  localparam logic [31:0] HALT_NOP      = 32'h0000_0000;
  localparam int unsigned CYCLE_TIMEOUT = 12500;

  // Bits needed to index n items; never less than 1.
  function automatic int unsigned cmp_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cmp_halt_detect.sv
// Per-node halt compare, halt latch and halt-cycle capture.
module cmp_halt_detect
  import cmp_pkg::*;
#(
  parameter int unsigned       INST_W      = 32,
  parameter int unsigned       CNT_W       = 32,
  parameter logic [INST_W-1:0] HALT_WORD   = INST_W'(HALT_NOP),
  parameter bit                STICKY_HALT = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              en,
  input  logic [INST_W-1:0] inst,
  input  logic [CNT_W-1:0]  cycle_count,
  output logic              halted,
  output logic [CNT_W-1:0]  halt_cycle,
  output logic              hit_c
);

  logic det_c;

  assign det_c = (inst == HALT_WORD);
  // Contribution to the all-halted condition for the current cycle.
  assign hit_c = STICKY_HALT ? (halted | det_c) : det_c;

  // Latch/mirror halt status and record the cycle of each rise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      halted     <= 1'b0;
      halt_cycle <= '0;
    end else if (en) begin
      if (det_c && !halted) halt_cycle <= cycle_count;
      if (STICKY_HALT) halted <= halted | det_c;
      else             halted <= det_c;
    end
  end

endmodule

// File: rtl/cmp_run_monitor.sv
// Run controller: halt monitoring, cycle counting, drain and dump sequencing.
module cmp_run_monitor
  import cmp_pkg::*;
#(
  parameter int unsigned       NODES          = 4,
  parameter int unsigned       INST_W         = 32,
  parameter int unsigned       CNT_W          = 32,
  parameter logic [INST_W-1:0] HALT_WORD      = INST_W'(HALT_NOP),
  parameter bit                STICKY_HALT    = 1'b1,
  parameter int unsigned       DRAIN_CYCLES   = 5,
  parameter int unsigned       DUMP_DEPTH     = 128,
  parameter int unsigned       ADDR_W         = 8,
  parameter int unsigned       TIMEOUT_CYCLES = CYCLE_TIMEOUT
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NODES*INST_W-1:0]      inst_in,
  output logic [NODES-1:0]             halted,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         running,
  output logic                         draining,
  output logic                         dump_valid,
  output logic [ADDR_W-1:0]            dump_addr,
  input  logic                         dump_ready,
  output logic                         done,
  output logic                         timeout,
  input  logic [cmp_clog2(NODES)-1:0]  node_sel,
  output logic [CNT_W-1:0]             node_halt_cycle
);

  localparam int unsigned SEL_W      = cmp_clog2(NODES);
  localparam int unsigned DRN_W      = cmp_clog2(DRAIN_CYCLES + 1);
  localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
  localparam int unsigned TOUT_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned DUMP_LAST  = (DUMP_DEPTH == 0) ? 0 : DUMP_DEPTH - 1;

  cmp_state_e       state_q, state_d;
  logic [NODES-1:0] hit_c;
  logic [CNT_W-1:0] halt_cycle [NODES];
  logic [CNT_W-1:0] tout_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic [CNT_W-1:0] sel_cycle_c;
  logic             run_c, all_hit_c, tout_hit_c, drain_last_c, dump_fire_c, dump_last_c;

  assign run_c        = (state_q == ST_RUN);
  assign all_hit_c    = &hit_c;
  assign tout_hit_c   = (TIMEOUT_CYCLES != 0) && (tout_cnt == CNT_W'(TOUT_LAST));
  assign drain_last_c = (drain_cnt == DRN_W'(DRAIN_LAST));
  assign dump_fire_c  = dump_valid && dump_ready;
  assign dump_last_c  = (dump_addr == ADDR_W'(DUMP_LAST));

  // One halt detector per node.
  for (genvar i = 0; i < NODES; i++) begin : g_node
    cmp_halt_detect #(
      .INST_W      (INST_W),
      .CNT_W       (CNT_W),
      .HALT_WORD   (HALT_WORD),
      .STICKY_HALT (STICKY_HALT)
    ) u_det (
      .CLK         (CLK),
      .RESET       (RESET),
      .en          (run_c),
      .inst        (inst_in[i*INST_W +: INST_W]),
      .cycle_count (cycle_count),
      .halted      (halted[i]),
      .halt_cycle  (halt_cycle[i]),
      .hit_c       (hit_c[i])
    );
  end

  // Next-state logic; halt beats timeout in RUN, timeout aborts DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (all_hit_c)       state_d = (DRAIN_CYCLES == 0) ? ST_DUMP : ST_DRAIN;
        else if (tout_hit_c) state_d = ST_TOUT;
      end
      ST_DRAIN: begin
        if (tout_hit_c)        state_d = ST_TOUT;
        else if (drain_last_c) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        if (dump_fire_c && dump_last_c) state_d = ST_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // State register and state-decoded status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      running    <= 1'b0;
      draining   <= 1'b0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      running    <= (state_d == ST_RUN);
      draining   <= (state_d == ST_DRAIN);
      dump_valid <= (state_d == ST_DUMP);
      done       <= done | (state_d == ST_DONE) | (state_d == ST_TOUT);
      timeout    <= timeout | (state_d == ST_TOUT);
    end
  end

  // Program cycle counter: saturating, frozen from the all-halted cycle on.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycle_count <= '0;
    end else if (run_c && !all_hit_c && (cycle_count != '1)) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  // Timeout counter keeps running through DRAIN while cycle_count is frozen.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tout_cnt <= '0;
    end else if ((state_q == ST_RUN || state_q == ST_DRAIN) && (tout_cnt != '1)) begin
      tout_cnt <= tout_cnt + CNT_W'(1);
    end
  end

  // Drain cycle counter, cleared outside DRAIN.
  always_ff @(posedge CLK) begin
    if (RESET)                  drain_cnt <= '0;
    else if (state_q == ST_DRAIN) drain_cnt <= drain_cnt + DRN_W'(1);
    else                        drain_cnt <= '0;
  end

  // Dump address sequencer; holds on stall and after the final address.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dump_addr <= '0;
    end else if ((state_q == ST_DUMP) && dump_fire_c && !dump_last_c) begin
      dump_addr <= dump_addr + ADDR_W'(1);
    end
  end

  // Halt-cycle select mux; out-of-range selects read 0.
  always_comb begin
    sel_cycle_c = '0;
    for (int unsigned i = 0; i < NODES; i++) begin
      if (node_sel == SEL_W'(i)) sel_cycle_c = halt_cycle[i];
    end
  end

  // Registered halt-cycle readout.
  always_ff @(posedge CLK) begin
    if (RESET) node_halt_cycle <= '0;
    else       node_halt_cycle <= sel_cycle_c;
  end

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Directed bench for cmp_run_monitor: sticky/live halt, drain, dump, timeout, reset.
module tb_cmp_run_monitor;
  import cmp_pkg::*;

  localparam int unsigned NODES  = 4;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned SEL_W  = cmp_clog2(NODES);
  localparam logic [INST_W-1:0] RUN_INST = 32'h0000_0013;

  logic CLK;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int failures;

  // Instance A: sticky, drain 5, timeout 100
  logic                    a_reset, a_running, a_draining, a_dvalid, a_dready, a_done, a_timeout;
  logic [NODES*INST_W-1:0] a_inst;
  logic [NODES-1:0]        a_halted;
  logic [CNT_W-1:0]        a_cycle, a_nhc;
  logic [ADDR_W-1:0]       a_daddr;
  logic [SEL_W-1:0]        a_sel;

  // Instance B: live halt vector, drain 5, no timeout
  logic                    b_reset, b_running, b_draining, b_dvalid, b_dready, b_done, b_timeout;
  logic [NODES*INST_W-1:0] b_inst;
  logic [NODES-1:0]        b_halted;
  logic [CNT_W-1:0]        b_cycle, b_nhc;
  logic [ADDR_W-1:0]       b_daddr;
  logic [SEL_W-1:0]        b_sel;

  // Instance C: sticky, no drain, no timeout
  logic                    c_reset, c_running, c_draining, c_dvalid, c_dready, c_done, c_timeout;
  logic [NODES*INST_W-1:0] c_inst;
  logic [NODES-1:0]        c_halted;
  logic [CNT_W-1:0]        c_cycle, c_nhc;
  logic [ADDR_W-1:0]       c_daddr;
  logic [SEL_W-1:0]        c_sel;

  cmp_run_monitor #(
    .NODES(NODES), .INST_W(INST_W), .CNT_W(CNT_W), .HALT_WORD(32'h0), .STICKY_HALT(1'b1),
    .DRAIN_CYCLES(5), .DUMP_DEPTH(128), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(100)
  ) u_a (
    .CLK(CLK), .RESET(a_reset), .inst_in(a_inst), .halted(a_halted), .cycle_count(a_cycle),
    .running(a_running), .draining(a_draining), .dump_valid(a_dvalid), .dump_addr(a_daddr),
    .dump_ready(a_dready), .done(a_done), .timeout(a_timeout), .node_sel(a_sel),
    .node_halt_cycle(a_nhc)
  );

  cmp_run_monitor #(
    .NODES(NODES), .INST_W(INST_W), .CNT_W(CNT_W), .HALT_WORD(32'h0), .STICKY_HALT(1'b0),
    .DRAIN_CYCLES(5), .DUMP_DEPTH(128), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(0)
  ) u_b (
    .CLK(CLK), .RESET(b_reset), .inst_in(b_inst), .halted(b_halted), .cycle_count(b_cycle),
    .running(b_running), .draining(b_draining), .dump_valid(b_dvalid), .dump_addr(b_daddr),
    .dump_ready(b_dready), .done(b_done), .timeout(b_timeout), .node_sel(b_sel),
    .node_halt_cycle(b_nhc)
  );

  cmp_run_monitor #(
    .NODES(NODES), .INST_W(INST_W), .CNT_W(CNT_W), .HALT_WORD(32'h0), .STICKY_HALT(1'b1),
    .DRAIN_CYCLES(0), .DUMP_DEPTH(128), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(0)
  ) u_c (
    .CLK(CLK), .RESET(c_reset), .inst_in(c_inst), .halted(c_halted), .cycle_count(c_cycle),
    .running(c_running), .draining(c_draining), .dump_valid(c_dvalid), .dump_addr(c_daddr),
    .dump_ready(c_dready), .done(c_done), .timeout(c_timeout), .node_sel(c_sel),
    .node_halt_cycle(c_nhc)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic [NODES*INST_W-1:0] pack_inst(input logic [NODES-1:0] mask);
    logic [NODES*INST_W-1:0] v;
    for (int i = 0; i < NODES; i++) v[i*INST_W +: INST_W] = mask[i] ? HALT_NOP : RUN_INST;
    return v;
  endfunction

  initial begin
    logic [NODES-1:0] mask;
    int               drain_seen;
    int               dvalid_seen;
    int unsigned      exp_addr;
    bit               exp_valid;
    bit               exp_done;

    checks = 0;
    failures = 0;
    a_reset = 1'b1; a_inst = pack_inst('0); a_dready = 1'b0; a_sel = '0;
    b_reset = 1'b1; b_inst = pack_inst('0); b_dready = 1'b0; b_sel = '0;
    c_reset = 1'b1; c_inst = pack_inst('0); c_dready = 1'b0; c_sel = '0;
    repeat (3) tick();

    // reset state
    chk_eq("rst_halted", 32'(a_halted), 32'h0);
    chk_eq("rst_cycle", a_cycle, 32'd0);
    chk_eq("rst_running", 32'(a_running), 32'd0);
    chk_eq("rst_dvalid", 32'(a_dvalid), 32'd0);
    chk_eq("rst_done", 32'(a_done), 32'd0);
    chk_eq("rst_nhc", a_nhc, 32'd0);

    // A run 1: nodes halt at cycles 10,20,30,40
    a_reset = 1'b0;
    drain_seen = 0;
    for (int k = 0; k <= 45; k++) begin
      mask = '0;
      for (int i = 0; i < NODES; i++) if (k == 10 * (i + 1)) mask[i] = 1'b1;
      a_inst = pack_inst(mask);
      if (k == 41) a_sel = SEL_W'(2);
      if (a_draining) drain_seen++;
      case (k)
        5:  chk_eq("a_cycle_5", a_cycle, 32'd5);
        10: chk_eq("a_halted_10", 32'(a_halted), 32'h0);
        11: chk_eq("a_halted_11", 32'(a_halted), 32'h1);
        21: chk_eq("a_halted_21", 32'(a_halted), 32'h3);
        31: chk_eq("a_halted_31", 32'(a_halted), 32'h7);
        40: begin
          chk_eq("a_running_40", 32'(a_running), 32'd1);
          chk_eq("a_draining_40", 32'(a_draining), 32'd0);
        end
        41: begin
          chk_eq("a_halted_41", 32'(a_halted), 32'hF);
          chk_eq("a_cycle_41", a_cycle, 32'd40);
          chk_eq("a_running_41", 32'(a_running), 32'd0);
          chk_eq("a_draining_41", 32'(a_draining), 32'd1);
          chk_eq("a_nhc_node0", a_nhc, 32'd10);
        end
        42: chk_eq("a_nhc_node2", a_nhc, 32'd30);
        45: chk_eq("a_cycle_45", a_cycle, 32'd40);
        default: ;
      endcase
      tick();
    end
    chk_eq("a_drain_len", 32'(drain_seen), 32'd5);
    chk_eq("a_draining_46", 32'(a_draining), 32'd0);

    // A dump with ready toggling 1,0,1,0
    exp_addr = 0; exp_valid = 1'b1; exp_done = 1'b0;
    for (int j = 0; j < 258; j++) begin
      chk_eq("a_dump_valid", 32'(a_dvalid), 32'(exp_valid));
      chk_eq("a_dump_addr", 32'(a_daddr), exp_addr);
      chk_eq("a_done", 32'(a_done), 32'(exp_done));
      a_dready = (j % 2 == 0);
      if (exp_valid && a_dready) begin
        if (exp_addr == 127) begin
          exp_valid = 1'b0;
          exp_done  = 1'b1;
        end else begin
          exp_addr++;
        end
      end
      tick();
    end
    chk_eq("a_done_halted", 32'(a_halted), 32'hF);
    chk_eq("a_done_cycle", a_cycle, 32'd40);
    chk_eq("a_done_timeout", 32'(a_timeout), 32'd0);

    // A run 2: reset while dumping at address 37
    a_reset = 1'b1; a_dready = 1'b1; a_sel = '0;
    repeat (2) tick();
    a_reset = 1'b0;
    for (int k = 0; k <= 46; k++) begin
      a_inst = pack_inst((k == 3) ? 4'hF : 4'h0);
      if (k == 9)  chk_eq("a_r2_dvalid_9", 32'(a_dvalid), 32'd1);
      if (k == 46) chk_eq("a_r2_addr_46", 32'(a_daddr), 32'd37);
      if (k < 46) tick();
    end
    a_reset = 1'b1;
    tick();
    chk_eq("a_mid_rst_halted", 32'(a_halted), 32'h0);
    chk_eq("a_mid_rst_cycle", a_cycle, 32'd0);
    chk_eq("a_mid_rst_dvalid", 32'(a_dvalid), 32'd0);
    chk_eq("a_mid_rst_addr", 32'(a_daddr), 32'd0);
    chk_eq("a_mid_rst_draining", 32'(a_draining), 32'd0);
    chk_eq("a_mid_rst_done", 32'(a_done), 32'd0);
    chk_eq("a_mid_rst_nhc", a_nhc, 32'd0);

    // A run 3: node3 never halts -> timeout at cycle 100
    a_reset = 1'b0;
    dvalid_seen = 0;
    for (int k = 0; k <= 102; k++) begin
      a_inst = pack_inst((k == 5) ? 4'h7 : 4'h0);
      if (a_dvalid) dvalid_seen++;
      case (k)
        0:   chk_eq("a_t_cycle_0", a_cycle, 32'd0);
        1:   chk_eq("a_t_running_1", 32'(a_running), 32'd1);
        4:   chk_eq("a_t_cycle_4", a_cycle, 32'd4);
        99:  begin
          chk_eq("a_t_timeout_99", 32'(a_timeout), 32'd0);
          chk_eq("a_t_done_99", 32'(a_done), 32'd0);
        end
        100: begin
          chk_eq("a_t_timeout_100", 32'(a_timeout), 32'd1);
          chk_eq("a_t_done_100", 32'(a_done), 32'd1);
          chk_eq("a_t_cycle_100", a_cycle, 32'd100);
          chk_eq("a_t_running_100", 32'(a_running), 32'd0);
          chk_eq("a_t_halted_100", 32'(a_halted), 32'h7);
        end
        102: chk_eq("a_t_timeout_102", 32'(a_timeout), 32'd1);
        default: ;
      endcase
      tick();
    end
    chk_eq("a_t_no_dump", 32'(dvalid_seen), 32'd0);

    // B: live halt vector, simultaneous halt at cycle 50
    b_reset = 1'b0;
    drain_seen = 0;
    for (int k = 0; k <= 52; k++) begin
      if (k >= 50)      b_inst = pack_inst(4'hF);
      else if (k == 10) b_inst = pack_inst(4'h1);
      else              b_inst = pack_inst(4'h0);
      if (k < 51 && b_draining) drain_seen++;
      case (k)
        11: chk_eq("b_halted_11", 32'(b_halted), 32'h1);
        12: begin
          chk_eq("b_halted_12", 32'(b_halted), 32'h0);
          chk_eq("b_nhc_node0", b_nhc, 32'd10);
        end
        50: begin
          chk_eq("b_running_50", 32'(b_running), 32'd1);
          chk_eq("b_halted_50", 32'(b_halted), 32'h0);
        end
        51: begin
          chk_eq("b_draining_51", 32'(b_draining), 32'd1);
          chk_eq("b_cycle_51", b_cycle, 32'd50);
          chk_eq("b_halted_51", 32'(b_halted), 32'hF);
        end
        default: ;
      endcase
      tick();
    end
    chk_eq("b_no_early_drain", 32'(drain_seen), 32'd0);

    // C: no drain, all nodes halt at cycle 7
    c_reset = 1'b0;
    drain_seen = 0;
    for (int k = 0; k <= 10; k++) begin
      c_inst = pack_inst((k == 7) ? 4'hF : 4'h0);
      if (c_draining) drain_seen++;
      if (k == 7) chk_eq("c_dvalid_7", 32'(c_dvalid), 32'd0);
      if (k == 8) begin
        chk_eq("c_dvalid_8", 32'(c_dvalid), 32'd1);
        chk_eq("c_addr_8", 32'(c_daddr), 32'd0);
        chk_eq("c_cycle_8", c_cycle, 32'd7);
      end
      tick();
    end
    chk_eq("c_never_draining", 32'(drain_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_run_monitor.md
Name: cmp_run_monitor

Overview:
- Synthesizable, parametrised run controller and monitor for an N-node Cardinal CMP.
- Watches each node's fetched instruction for the halt word and counts the cycles the program takes.
- After all nodes halt, it drains the pipeline for a fixed number of cycles, then sequences a memory dump address stream over a valid/ready handshake.
- Sits beside cardinal_cmp, replacing the ad-hoc halt/count/flush/dump logic in simulation and allowing on-chip use.

Parameters:
- NODES, 4, number of CPU nodes monitored (1..16)
- INST_W, 32, instruction width per node
- CNT_W, 32, cycle counter width
- HALT_WORD, 32'h00000000, instruction value treated as halt
- STICKY_HALT, 1, 1 = per-node halt latched at first detection; 0 = all nodes must show HALT_WORD in the same cycle
- DRAIN_CYCLES, 5, cycles between all-halted and dump start (0 allowed)
- DUMP_DEPTH, 128, number of dump addresses issued
- ADDR_W, 8, dump address width
- TIMEOUT_CYCLES, 12500, abort threshold in cycles; 0 disables

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset
- inst_in  in  NODES*INST_W  node i instruction on bits [i*INST_W +: INST_W]
- halted  out  NODES  per-node halt status
- cycle_count  out  CNT_W  cycles since reset release
- running  out  1  FSM in RUN
- draining  out  1  FSM in DRAIN
- dump_valid  out  1  dump address valid
- dump_addr  out  ADDR_W  memory location to dump
- dump_ready  in  1  consumer accepts dump_addr
- done  out  1  run finished (sticky)
- timeout  out  1  run aborted by timeout (sticky)
- node_sel  in  clog2(NODES) (min 1)  halt-cycle readout select
- node_halt_cycle  out  CNT_W  halt cycle of node_sel, registered, 1-cycle latency

Behaviour:
- Reset: RESET is synchronous and active-high; clock is CLK. While RESET=1, every output is 0 and the FSM is in RUN with its counters cleared. An assertion mid-operation aborts from any state.
- FSM states: RUN, DRAIN, DUMP, DONE, TOUT.
- RUN:
  - cycle_count increments each cycle; it saturates at all-ones and does not wrap.
  - Node i halt detect: inst_in slice == HALT_WORD, sampled at the posedge.
  - With STICKY_HALT=1, halted[i] sets at first detect and holds; halt_cycle[i] captures the cycle_count value of that cycle.
  - With STICKY_HALT=0, halted mirrors the current-cycle detect vector; halt_cycle[i] is captured on each 0->1 rise.
  - When all bits of the detect condition are 1 (sticky halted vector, or the simultaneous vector): go to DRAIN; cycle_count freezes at its value in that cycle.
- DRAIN: count DRAIN_CYCLES cycles, then go to DUMP. With DRAIN_CYCLES=0, go RUN->DUMP directly.
- DUMP:
  - dump_valid=1 and dump_addr starts at 0.
  - On dump_valid&&dump_ready, dump_addr increments.
  - Acceptance of address DUMP_DEPTH-1 -> DONE. dump_valid deasserts the next cycle and dump_addr holds its last value.
  - dump_addr is stable while valid && !ready.
- DONE: done=1 until RESET; halted and cycle_count hold.
- TOUT:
  - Entered from RUN or DRAIN when TIMEOUT_CYCLES!=0 and the cycle count reaches TIMEOUT_CYCLES.
  - In DRAIN, cycle_count is frozen, so that check uses a separate free-running counter.
  - On entry, timeout=1 and done=1. No dump is issued.
  - If the all-halted condition and the timeout hit in the same cycle, halt wins and the FSM goes to DRAIN.
- node_halt_cycle: registered readout of halt_cycle[node_sel]. It reads 0 for a node that has not halted. node_sel >= NODES returns 0.
- running and draining are decoded from the state register; they are not combinational on inputs.

Decomposition:
- Shared package cmp_pkg holds:
  - the FSM state enum
  - HALT_NOP constant (32'h0)
  - default CYCLE_TIMEOUT
  - the clog2 helper function
- One natural sub-module: cmp_halt_detect, which does per-node compare, sticky latch and halt-cycle capture, one instance per node via generate. The top module holds the FSM, counters and dump sequencer.

Test Plan:
- NODES=4, STICKY=1; nodes halt at cycles 10, 20, 30, 40 -> halted 0001..1111 in sequence; cycle_count freezes at 40; node_halt_cycle for node_sel=2 reads 30 one cycle after select; draining is 1 for 5 cycles.
- STICKY=0; node0 shows 0 at cycle 10, then a non-zero instruction; all nodes show 0 together at cycle 50 -> no DRAIN before cycle 50; DRAIN entered then; halted mirrors the live vector.
- DUMP_DEPTH=128, dump_ready toggling 1,0,1,0 -> dump_addr values 0..127 each accepted exactly once and held when stalled; done rises the cycle after acceptance of 127.
- TIMEOUT_CYCLES=100, node3 never halts -> timeout=1 and done=1 at cycle 100; dump_valid never asserts.
- RESET asserted in DUMP at dump_addr=37 -> next cycle all outputs 0, FSM in RUN; after release, cycle_count restarts from 0.
- DRAIN_CYCLES=0 with all nodes halting at cycle 7 -> dump_valid=1 on the cycle after the halt detect; draining never asserts.
